// File: rtl/prime_pkg.sv
// Shared state encoding and width helper for the prime sieve engine.
package prime_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SCAN   = 3'd2,
    MARK   = 3'd3,
    READY  = 3'd4,
    STREAM = 3'd5
  } state_e;

  function automatic int num_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/prime_bitmap.sv
// N_MAX-entry primality bitmap: one synchronous write port, two combinational read ports.
module prime_bitmap
  import prime_pkg::*;
#(
  parameter int N_MAX = 1024,
  parameter int NUM_W = num_w(N_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [NUM_W-1:0] waddr,
  input  logic             wdata,
  input  logic [NUM_W-1:0] raddr_a,
  output logic             rdata_a,
  input  logic [NUM_W-1:0] raddr_b,
  output logic             rdata_b
);

  localparam logic [NUM_W:0] LIMIT = (NUM_W+1)'(N_MAX);

  logic [N_MAX-1:0] bits_q;
  logic [N_MAX-1:0] bits_d;

  // Next bitmap contents from the single write port
  always_comb begin
    bits_d = bits_q;
    if (we) begin
      bits_d[waddr] = wdata;
    end else begin
      bits_d = bits_q;
    end
  end

  // Bitmap storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  // Read ports; addresses past the sieved range (non-power-of-two N_MAX) read as composite
  always_comb begin
    if ({1'b0, raddr_a} < LIMIT) begin
      rdata_a = bits_q[raddr_a];
    end else begin
      rdata_a = 1'b0;
    end
    if ({1'b0, raddr_b} < LIMIT) begin
      rdata_b = bits_q[raddr_b];
    end else begin
      rdata_b = 1'b0;
    end
  end

endmodule

// File: rtl/prime_sieve_engine.sv
// Sequential Sieve of Eratosthenes over 0..N_MAX-1 with point queries and
// a valid/ready prime stream for a requested [lo,hi] window.
module prime_sieve_engine
  import prime_pkg::*;
#(
  parameter int N_MAX = 1024,
  parameter int NUM_W = num_w(N_MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             sieve_done,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [NUM_W-1:0] q_num,
  output logic             r_valid,
  output logic             r_prime,
  output logic             r_oob,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [NUM_W-1:0] s_lo,
  input  logic [NUM_W-1:0] s_hi,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [NUM_W-1:0] o_data,
  output logic             o_end,
  output logic [NUM_W:0]   o_count
);

  localparam logic [NUM_W:0]     LIMIT1 = (NUM_W+1)'(N_MAX);
  localparam logic [2*NUM_W-1:0] LIMIT2 = (2*NUM_W)'(N_MAX);
  localparam logic [NUM_W-1:0]   LAST   = NUM_W'(N_MAX - 1);
  localparam logic [NUM_W-1:0]   ONE_N  = NUM_W'(1);
  localparam logic [NUM_W-1:0]   TWO_N  = NUM_W'(2);
  localparam logic [NUM_W:0]     ZERO_W = (NUM_W+1)'(0);
  localparam logic [NUM_W:0]     ONE_W  = (NUM_W+1)'(1);
  localparam logic [NUM_W:0]     TWO_W  = (NUM_W+1)'(2);

  state_e             state_q, state_d;
  logic [NUM_W-1:0]   p_q, p_d, end_q, end_d, o_data_q, o_data_d;
  logic [NUM_W:0]     m_q, m_d, cur_q, cur_d, cnt_q, cnt_d, o_count_q, o_count_d;
  logic               busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;
  logic               r_valid_q, r_valid_d, r_prime_q, r_prime_d, r_oob_q, r_oob_d;
  logic               o_valid_q, o_valid_d, o_end_q, o_end_d;

  logic               we_s, wdata_s, rd_a_s, rd_b_s, q_oob_s;
  logic [NUM_W-1:0]   waddr_s, raddr_a_s, s_end_s;
  logic [NUM_W:0]     m_next_s;
  logic [2*NUM_W-1:0] pp_s;

  prime_bitmap #(.N_MAX(N_MAX), .NUM_W(NUM_W)) u_bitmap (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we_s),
    .waddr  (waddr_s),
    .wdata  (wdata_s),
    .raddr_a(raddr_a_s),
    .rdata_a(rd_a_s),
    .raddr_b(cur_q[NUM_W-1:0]),
    .rdata_b(rd_b_s)
  );

  assign pp_s     = {{NUM_W{1'b0}}, p_q} * {{NUM_W{1'b0}}, p_q};
  assign m_next_s = m_q + {1'b0, p_q};
  assign q_oob_s  = ({1'b0, q_num} >= LIMIT1);
  assign s_end_s  = ({1'b0, s_hi} >= LIMIT1) ? LAST : s_hi;

  // The handshake readies gate on same-cycle start/query so neither request is taken on those cycles
  assign q_ready = rdy_q & ~start;
  assign s_ready = rdy_q & ~start & ~q_valid;

  // Next-state, bitmap port control and output computation
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    cur_d     = cur_q;
    end_d     = end_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    r_valid_d = 1'b0;
    r_prime_d = r_prime_q;
    r_oob_d   = r_oob_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_end_d   = 1'b0;
    o_count_d = o_count_q;
    we_s      = 1'b0;
    waddr_s   = cur_q[NUM_W-1:0];
    wdata_s   = 1'b0;
    raddr_a_s = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cur_d   = ZERO_W;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        we_s    = 1'b1;
        wdata_s = (cur_q >= TWO_W);
        if (cur_q[NUM_W-1:0] == LAST) begin
          p_d     = TWO_N;
          state_d = SCAN;
        end else begin
          cur_d = cur_q + ONE_W;
        end
      end
      SCAN: begin
        if (pp_s >= LIMIT2) begin
          state_d = READY;
          done_d  = 1'b1;
        end else if (rd_a_s) begin
          m_d     = pp_s[NUM_W:0];
          state_d = MARK;
        end else begin
          p_d = p_q + ONE_N;
        end
      end
      MARK: begin
        we_s    = 1'b1;
        waddr_s = m_q[NUM_W-1:0];
        m_d     = m_next_s;
        if (m_next_s >= LIMIT1) begin
          p_d     = p_q + ONE_N;
          state_d = SCAN;
        end else begin
          state_d = MARK;
        end
      end
      READY: begin
        raddr_a_s = q_num;
        if (start) begin
          state_d = CLEAR;
          cur_d   = ZERO_W;
        end else if (q_valid) begin
          r_valid_d = 1'b1;
          r_prime_d = rd_a_s & ~q_oob_s;
          r_oob_d   = q_oob_s;
        end else if (s_valid) begin
          cur_d = {1'b0, s_lo};
          end_d = s_end_s;
          cnt_d = ZERO_W;
          if (s_lo > s_end_s) begin
            o_end_d   = 1'b1;
            o_count_d = ZERO_W;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = READY;
        end
      end
      STREAM: begin
        if (o_valid_q && !o_ready) begin
          o_valid_d = 1'b1;
        end else begin
          // A beat accepted on this edge still lets the cursor load the next prime
          cnt_d = cnt_q + (o_valid_q ? ONE_W : ZERO_W);
          if (cur_q > {1'b0, end_q}) begin
            o_valid_d = 1'b0;
            o_end_d   = 1'b1;
            o_count_d = cnt_d;
            state_d   = READY;
          end else begin
            if (rd_b_s) begin
              o_valid_d = 1'b1;
              o_data_d  = cur_q[NUM_W-1:0];
            end else begin
              o_valid_d = 1'b0;
            end
            cur_d = cur_q + ONE_W;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CLEAR) || (state_d == SCAN) || (state_d == MARK);
    rdy_d  = (state_d == READY);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      m_q       <= '0;
      cur_q     <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdy_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_prime_q <= 1'b0;
      r_oob_q   <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_end_q   <= 1'b0;
      o_count_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      cur_q     <= cur_d;
      end_q     <= end_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdy_q     <= rdy_d;
      r_valid_q <= r_valid_d;
      r_prime_q <= r_prime_d;
      r_oob_q   <= r_oob_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_end_q   <= o_end_d;
      o_count_q <= o_count_d;
    end
  end

  assign busy       = busy_q;
  assign sieve_done = done_q;
  assign r_valid    = r_valid_q;
  assign r_prime    = r_prime_q;
  assign r_oob      = r_oob_q;
  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign o_end      = o_end_q;
  assign o_count    = o_count_q;

endmodule
